// File: rtl/ram_16x8_sync.sv
// 16 x 8 single-port RAM: synchronous write, registered write-first read, sync active-high reset.
// Define RAM_16X8_PARITY_EN to store an even-parity bit per entry and expose par_err.
module ram_16x8_sync (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [3:0] addr,
  input  logic [7:0] din,
`ifdef RAM_16X8_PARITY_EN
  output logic [7:0] dout,
  output logic       par_err
`else
  output logic [7:0] dout
`endif
);

  localparam int unsigned Depth = 16;
`ifdef RAM_16X8_PARITY_EN
  localparam int unsigned WordW = 9;
`else
  localparam int unsigned WordW = 8;
`endif

  logic [WordW-1:0] mem_q [Depth];
  logic [WordW-1:0] mem_d [Depth];
  logic [7:0]       dout_q, dout_d;
  logic [WordW-1:0] wr_word;

`ifdef RAM_16X8_PARITY_EN
  logic perr_q, perr_d;

  // Stored word is {parity, data}; XOR over all 9 bits is 0 when consistent.
  assign wr_word = {^din, din};
`else
  assign wr_word = din;
`endif

  always_comb begin
    mem_d  = mem_q;
    dout_d = dout_q;
`ifdef RAM_16X8_PARITY_EN
    perr_d = 1'b0;
`endif
    if (wr_en) begin
      mem_d[addr] = wr_word;
      dout_d      = din;
    end else begin
      dout_d = mem_q[addr][7:0];
`ifdef RAM_16X8_PARITY_EN
      perr_d = ^mem_q[addr];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      dout_q <= 8'h00;
`ifdef RAM_16X8_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      mem_q  <= mem_d;
      dout_q <= dout_d;
`ifdef RAM_16X8_PARITY_EN
      perr_q <= perr_d;
`endif
    end
  end

  assign dout = dout_q;
`ifdef RAM_16X8_PARITY_EN
  assign par_err = perr_q;
`endif

endmodule

// File: tb/tb_ram_16x8_sync.sv
// Scoreboard bench for ram_16x8_sync: driver pushes expected dout per cycle, monitor pops/compares.
// Build with RAM_16X8_PARITY_EN to also check par_err and the corruption case.
module tb_ram_16x8_sync;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [3:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       par_err_obs;

`ifdef RAM_16X8_PARITY_EN
  logic par_err;
  assign par_err_obs = par_err;
`else
  assign par_err_obs = 1'b0;
`endif

  ram_16x8_sync dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .addr    (addr),
    .din     (din),
`ifdef RAM_16X8_PARITY_EN
    .dout    (dout),
    .par_err (par_err)
`else
    .dout    (dout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    string      tag;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] ref_mem [16];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         flipped [16];

  // One clock of stimulus; the expected post-edge output is pushed after the edge.
  task automatic op(input logic r, input logic we, input logic [3:0] a, input logic [7:0] d,
                    input string tag);
    exp_t e;
    @(negedge clk);
    rst   = r;
    wr_en = we;
    addr  = a;
    din   = d;
    @(posedge clk);
    e.tag  = tag;
    e.perr = 1'b0;
    if (r) begin
      for (int i = 0; i < 16; i++) begin
        ref_mem[i] = 8'h00;
        flipped[i] = 1'b0;
      end
      e.data = 8'h00;
    end else if (we) begin
      ref_mem[a] = d;
      flipped[a] = 1'b0;
      e.data     = d;
    end else begin
      e.data = ref_mem[a];
      e.perr = flipped[a];
    end
    sb_q.push_back(e);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d, input string tag);
    op(1'b0, 1'b1, a, d, tag);
  endtask

  task automatic rd(input logic [3:0] a, input string tag);
    op(1'b0, 1'b0, a, 8'h00, tag);
  endtask

  // Monitor: dout is a register, so it is stable at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_cmp++;
        if (dout !== e.data) begin
          n_bad++;
          $display("FAIL %s dout: got %02h expected %02h", e.tag, dout, e.data);
        end
`ifdef RAM_16X8_PARITY_EN
        n_cmp++;
        if (par_err_obs !== e.perr) begin
          n_bad++;
          $display("FAIL %s par_err: got %0b expected %0b", e.tag, par_err_obs, e.perr);
        end
`endif
      end
    end
  end

  initial begin
    int budget;
    rst   = 1'b1;
    wr_en = 1'b0;
    addr  = 4'h0;
    din   = 8'h00;
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = 8'h00;
      flipped[i] = 1'b0;
    end

    op(1'b1, 1'b0, 4'h0, 8'h00, "reset");
    for (int i = 0; i < 16; i++) rd(4'(i), "reset_clear");

    wr(4'h1, 8'hAA, "wr_aa");
    wr(4'h2, 8'h55, "wr_55");
    rd(4'h1, "rd_aa");
    rd(4'h2, "rd_55");

    wr(4'h7, 8'h3C, "write_first");
    rd(4'h7, "rd_after_wf");

    for (int i = 0; i < 16; i++) wr(4'(i), 8'hF0 | 8'(i), "sweep_wr");
    for (int i = 0; i < 16; i++) rd(4'(i), "sweep_rd");

    wr(4'h9, 8'h11, "same_addr_1");
    wr(4'h9, 8'h22, "same_addr_2");
    rd(4'h9, "last_wins");

    op(1'b1, 1'b1, 4'h4, 8'h99, "rst_prio");
    rd(4'h4, "rst_prio_rd");

    wr(4'h3, 8'h12, "pre_rst_wr");
    wr(4'hC, 8'h34, "pre_rst_wr");
    wr(4'hF, 8'h56, "pre_rst_wr");
    op(1'b1, 1'b0, 4'h0, 8'h00, "mid_rst");
    rd(4'h3, "mid_rst_rd");
    rd(4'hC, "mid_rst_rd");
    rd(4'hF, "mid_rst_rd");

`ifdef RAM_16X8_PARITY_EN
    wr(4'h5, 8'hAA, "par_wr");
    wr(4'h6, 8'h01, "par_wr");
    rd(4'h5, "par_rd_ok");
    rd(4'h6, "par_rd_ok");
    @(negedge clk);
    dut.mem_q[6] = dut.mem_q[6] ^ 9'h002;
    ref_mem[6]   = ref_mem[6] ^ 8'h02;
    flipped[6]   = 1'b1;
    rd(4'h6, "par_corrupt");
`endif

    for (int n = 0; n < 400; n++) begin
      logic [3:0] a;
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) op(1'b1, 1'($urandom_range(0, 1)), a, 8'($urandom), "rand_rst");
      else if ($urandom_range(0, 1) == 1) wr(a, 8'($urandom), "rand_wr");
      else rd(a, "rand_rd");
    end

    budget = 0;
    while (sb_q.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    @(posedge clk);
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
